// File: rtl/addsub36_seq.sv
// Issue/collect controller for a two-stage registered add/sub datapath (e0/e1 -> e2).
// Tracks which stages hold live data and returns each result on a backpressured stream.
module addsub36_seq #(
    parameter int CNT_W = 16,
    parameter int W     = 36
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [W-1:0]     dp_a,
    output logic [W-1:0]     dp_b,
    output logic             dp_sign,
    output logic             dp_en0,
    output logic             dp_en1,
    output logic             dp_en2,
    input  logic [W-1:0]     dp_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_done,
    output logic             busy
);

    // Handshake: a transfer occurs on a rising edge where valid and ready are both high.
    // valid never depends on ready; in_ready depends only on pipeline state, out_ready and flush.
    logic             r_v1;
    logic             r_v2;
    logic             r_sub1;
    logic             r_last1;
    logic             r_last2;
    logic [CNT_W-1:0] r_cnt_issued;
    logic [CNT_W-1:0] r_cnt_done;

    logic             w_adv2;
    logic             w_acc;
    logic             w_done;

    // Stage 1 may move into e2 when e2 is empty or is being drained this cycle.
    assign w_adv2   = r_v1 & (~r_v2 | out_ready);
    assign in_ready = ~flush & (~r_v1 | w_adv2);
    assign w_acc    = in_valid & in_ready;
    assign w_done   = r_v2 & out_ready;

    assign dp_a     = in_a;
    assign dp_b     = in_b;
    assign dp_sign  = r_sub1;
    assign dp_en0   = w_acc;
    assign dp_en1   = w_acc;
    assign dp_en2   = w_adv2 & ~flush;

    assign out_valid  = r_v2;
    assign out_data   = dp_x;
    assign out_last   = r_last2;
    assign cnt_issued = r_cnt_issued;
    assign cnt_done   = r_cnt_done;
    assign busy       = r_v1 | r_v2;

    // Flush only drops the valid bits; stale datapath contents stay masked by them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_sub1       <= 1'b0;
            r_last1      <= 1'b0;
            r_last2      <= 1'b0;
            r_cnt_issued <= '0;
            r_cnt_done   <= '0;
        end else if (flush) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_cnt_issued <= '0;
            r_cnt_done   <= '0;
        end else begin
            r_v1 <= w_acc | (r_v1 & ~w_adv2);
            r_v2 <= w_adv2 | (r_v2 & ~out_ready);
            if (w_acc) begin
                r_sub1  <= in_sub;
                r_last1 <= in_last;
            end
            if (w_adv2) begin
                r_last2 <= r_last1;
            end
            if (w_acc) begin
                r_cnt_issued <= r_cnt_issued + CNT_W'(1);
            end
            if (w_done) begin
                r_cnt_done <= r_cnt_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/addsub36_seq.md
Name: addsub36_seq

Overview:
- Upstream issue/collect controller for the 36-bit registered add/sub datapath (operand registers e0/e1, result register e2).
- Accepts operand pairs over a valid/ready stream and drives the datapath's a, b, sign, en0, en1 and en2.
- Tracks which datapath stages hold live data and returns each result on a valid/ready output stream with backpressure.
- Full throughput of 1 op/cycle; a stalled output holds the datapath without losing data.

Parameters:
- CNT_W, 16, width of the issued/completed operation counters.
- W, 36, operand/result width; must match the datapath width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_sub  in  1  1 = A-B, 0 = A+B
- in_last  in  1  sideband, travels with the op
- dp_a  out  W  to datapath a
- dp_b  out  W  to datapath b
- dp_sign  out  1  to datapath sign
- dp_en0  out  1  to datapath en0
- dp_en1  out  1  to datapath en1
- dp_en2  out  1  to datapath en2
- dp_x  in  W  datapath result x
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  W  result
- out_last  out  1  sideband of the result
- cnt_issued  out  CNT_W  ops accepted since reset/clear
- cnt_done  out  CNT_W  results delivered since reset/clear
- busy  out  1  v1 | v2

Behaviour:
- Clocking and reset: clk; reset reset_n, asynchronous, active-low.
- Reset clears v1, v2, sub1, last1, last2, cnt_issued and cnt_done to 0.
- Outputs at reset:
  - out_valid=0, in_ready=1, busy=0.
  - dp_en0/1/2=0.
  - out_data follows dp_x (0 after datapath reset).
- State:
  - v1: e0/e1 hold a live op; sub1/last1 are its attributes.
  - v2: e2 holds a live result; last2 is its attribute.
- Advance conditions:
  - adv2 = v1 & (~v2 | out_ready).
  - in_ready = ~v1 | adv2.
  - acc = in_valid & in_ready.
- Datapath drive:
  - dp_a = in_a, dp_b = in_b (combinational pass-through).
  - dp_en0 = dp_en1 = acc.
  - dp_en2 = adv2.
  - dp_sign = sub1 (the op in e0/e1, never in_sub).
- Register updates each edge:
  - v1 <= acc | (v1 & ~adv2).
  - sub1/last1 <= in_sub/in_last when acc.
  - v2 <= adv2 | (v2 & ~out_ready).
  - last2 <= last1 when adv2.
- Output:
  - out_valid = v2, out_data = dp_x, out_last = last2.
- Latency:
  - Op accepted at edge k is visible on out_data after edge k+1 if stage 2 is free: 1 cycle acceptance-to-valid.
  - Back-to-back accepts give back-to-back results.
- Backpressure:
  - With v1=v2=1 and out_ready=0: in_ready=0 and all dp_en are 0; e0/e1/e2 hold.
  - When out_ready returns, result and pending op each advance one stage in the same edge, and a new op may be accepted in that same edge.
- Counters:
  - cnt_issued += 1 on acc; cnt_done += 1 on out_valid & out_ready.
  - Both wrap modulo 2^CNT_W with no saturation.
- flush (synchronous, highest priority over all other updates):
  - Next edge: v1=v2=0 and both counters cleared.
  - in_ready=0 and dp_en0/1/2 forced 0 while flush=1; an in_valid in that cycle is not accepted.
  - Datapath registers are not cleared; stale data is masked by v1/v2.
- Reset mid-operation: all in-flight ops are dropped with no output handshake; in_ready=1 on the first cycle after reset_n rises.
- Arithmetic: modulo 2^W, performed by the datapath. The controller does no overflow detection.

Test Plan:
- Single add: a=36'h0_0000_0005, b=3, sub=0 accepted at edge k, out_ready=1 -> out_valid after edge k+1, out_data=8, cnt_issued=cnt_done=1.
- Subtract wrap: a=0, b=1, sub=1 -> out_data=36'hF_FFFF_FFFF.
- Mixed stream: four back-to-back ops (add, sub, add, sub) with in_last on the 4th and out_ready=1 -> four consecutive results with the correct sign each, out_last only on the 4th, in_ready never low.
- Backpressure: out_ready=0 for 5 cycles with continuous input -> exactly 2 ops accepted, in_ready=0 while full, dp_en all 0, e2 unchanged. On release, results arrive in order with no loss or duplication.
- Flush: flush pulsed with v1=v2=1 -> busy=0, out_valid=0, counters=0 next cycle; the following op returns the correct result.
- Async reset: reset_n low mid-stream (asserted between clock edges) -> out_valid=0 and counters 0 immediately; counters wrap from 16'hFFFF to 0 with CNT_W=16.
